// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and constants for the truth-table sweeper and its function unit.
package truth_table_sweeper_pkg;

   localparam int NUM_VECTORS = 16;
   localparam int VEC_W       = 4;

   // Reference truth table of the function unit: only abcd = 1110 is true.
   localparam logic [NUM_VECTORS-1:0] GOLDEN_MASK = 16'h4000;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/truth_table_sweeper_logic_unit_4in.sv
// Combinational 4-input function unit: s = a & b & c & ~d, with {a,b,c,d} = vec.
module logic_unit_4in
   import truth_table_sweeper_pkg::*;
(
   input  logic [VEC_W-1:0] vec,
   output logic             s
);

   // Purely combinational product term.
   always_comb s = vec[3] & vec[2] & vec[1] & ~vec[0];

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive sweeper for logic_unit_4in: walks all 16 vectors, holds each for
// SETTLE_CYCLES, samples the output into a truth table and compares it against
// a caller-supplied mask.
// Optional build macro SWEEP_EARLY_ABORT_EN: stop the sweep at the first mismatch.
module truth_table_sweeper
   import truth_table_sweeper_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [NUM_VECTORS-1:0] expected,
   output logic [VEC_W-1:0]       vec,
   output logic                   busy,
   output logic                   done,
   output logic [NUM_VECTORS-1:0] table_out,
   output logic                   mismatch,
   output logic [VEC_W-1:0]       first_fail_idx
);

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
   localparam logic [VEC_W-1:0] LAST_IDX = VEC_W'(NUM_VECTORS - 1);

   state_t                 state, state_nx;
   logic [VEC_W-1:0]       idx;
   logic [3:0]             settle_cnt;
   logic [NUM_VECTORS-1:0] expected_q;
   logic                   s;
   logic                   bit_bad;

   logic_unit_4in u_logic_unit (
      .vec (idx),
      .s   (s)
   );

   // A captured bit disagrees with the latched expectation for the current vector.
   always_comb bit_bad = (s != expected_q[idx]);

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state decode; termination is decided on idx = 15 so idx never wraps.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:   if (start) state_nx = SETTLE;
         SETTLE: if (settle_cnt == SETTLE_LAST) state_nx = SAMPLE;
         SAMPLE: begin
            if (idx == LAST_IDX) state_nx = DONE;
`ifdef SWEEP_EARLY_ABORT_EN
            else if (bit_bad && !mismatch) state_nx = DONE;
`endif
            else state_nx = SETTLE;
         end
         DONE:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Counters, latched mask and capture registers; results hold until the next start.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx            <= '0;
         settle_cnt     <= '0;
         expected_q     <= '0;
         table_out      <= '0;
         mismatch       <= 1'b0;
         first_fail_idx <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               expected_q     <= expected;
               table_out      <= '0;
               mismatch       <= 1'b0;
               first_fail_idx <= '0;
               idx            <= '0;
               settle_cnt     <= '0;
            end
            SETTLE: settle_cnt <= settle_cnt + 4'd1;
            SAMPLE: begin
               table_out[idx] <= s;
               if (bit_bad && !mismatch) begin
                  mismatch       <= 1'b1;
                  first_fail_idx <= idx;
               end
               if (state_nx == SETTLE) begin
                  idx        <= idx + 1'b1;
                  settle_cnt <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // Status outputs decoded straight from state; vec follows idx.
   always_comb begin
      vec  = idx;
      busy = (state == SETTLE) || (state == SAMPLE);
      done = (state == DONE);
   end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper (SETTLE_CYCLES = 1 and 3 instances).
module tb_truth_table_sweeper;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] expected = 16'h0000;

   logic [3:0]  vec1, vec3, ffi1, ffi3;
   logic        busy1, busy3, done1, done3, mm1, mm3;
   logic [15:0] tab1, tab3;

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   truth_table_sweeper #(.SETTLE_CYCLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .expected(expected),
      .vec(vec1), .busy(busy1), .done(done1), .table_out(tab1),
      .mismatch(mm1), .first_fail_idx(ffi1));

   truth_table_sweeper #(.SETTLE_CYCLES(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start), .expected(expected),
      .vec(vec3), .busy(busy3), .done(done3), .table_out(tab3),
      .mismatch(mm3), .first_fail_idx(ffi3));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Pulse start for one cycle and count edges until done; lat = limit on timeout.
   task automatic run(input logic [15:0] m, input bit use3, input int limit, output int lat);
      expected = m;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1;
      while (!(use3 ? done3 : done1) && lat < limit) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   initial begin
      int lat;
      int bad;

      // Reset state
      do_reset();
      chk("rst_vec", vec1, 0);
      chk("rst_busy", busy1, 0);
      chk("rst_done", done1, 0);
      chk("rst_table", tab1, 0);
      chk("rst_mm", mm1, 0);
      chk("rst_ffi", ffi1, 0);

      // Golden mask sweep
      run(16'h4000, 1'b0, 200, lat);
      chk("gold_lat", lat, 33);
      chk("gold_done", done1, 1);
      chk("gold_table", tab1, 16'h4000);
      chk("gold_mm", mm1, 0);
      chk("gold_ffi", ffi1, 0);
      @(posedge clk); #1;
      chk("done_pulse", done1, 0);
      chk("gold_hold", tab1, 16'h4000);

      // All-zero expectation: vector 14 is the only failure
      do_reset();
      run(16'h0000, 1'b0, 200, lat);
      chk("zero_lat", lat, 33);
      chk("zero_mm", mm1, 1);
      chk("zero_ffi", ffi1, 14);
      chk("zero_table", tab1, 16'h4000);

      // All-ones expectation: vector 0 fails first
      do_reset();
      run(16'hFFFF, 1'b0, 200, lat);
      chk("ones_mm", mm1, 1);
      chk("ones_ffi", ffi1, 0);
`ifdef SWEEP_EARLY_ABORT_EN
      chk("ones_lat", lat, 3);
      chk("ones_table", tab1, 16'h0000);
`else
      chk("ones_lat", lat, 33);
      chk("ones_table", tab1, 16'h4000);
`endif

      // Start held high: exactly one sweep, next one only after done
      do_reset();
      expected = 16'h4000;
      start = 1'b1;
      @(posedge clk); #1;
      lat = 1;
      while (!done1 && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("hold_lat", lat, 33);
      @(posedge clk); #1;
      chk("hold_idle_busy", busy1, 0);
      chk("hold_idle_done", done1, 0);
      @(posedge clk); #1;
      chk("hold_restart_busy", busy1, 1);
      start = 1'b0;

      // Mid-sweep reset after a mismatch has been recorded
      do_reset();
      expected = 16'hFFFF;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      chk("mid_mm_before", mm1, 1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("mid_busy", busy1, 0);
      chk("mid_table", tab1, 0);
      chk("mid_mm", mm1, 0);
      chk("mid_vec", vec1, 0);
      rst_n = 1'b1;
      run(16'h4000, 1'b0, 200, lat);
      chk("mid_fresh_lat", lat, 33);
      chk("mid_fresh_table", tab1, 16'h4000);
      chk("mid_fresh_mm", mm1, 0);

      // SETTLE_CYCLES = 3: vec steps every 4 cycles, 0..15
      do_reset();
      expected = 16'h4000;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1;
      bad = 0;
      while (!done3 && lat < 300) begin
         if (vec3 != 4'((lat - 1) / 4)) bad++;
         @(posedge clk); #1;
         lat++;
      end
      chk("s3_lat", lat, 65);
      chk("s3_vec_seq_errs", bad, 0);
      chk("s3_table", tab3, 16'h4000);
      chk("s3_mm", mm3, 0);
      chk("s3_vec_hold", vec3, 15);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
